// File: rtl/fsm_seq_driver_pkg.sv
// Shared definitions for the A/K1/K2 sequence driver: driver state encodings
// and the 2-bit controller state codes used by monitors and benches.
package fsm_seq_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } drv_state_e;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'b00,
        CTRL_START = 2'b01,
        CTRL_STOP  = 2'b10,
        CTRL_CLEAR = 2'b11
    } ctrl_state_e;

    localparam int CNT_W = 8;

    // Controller state a well-behaved controller should occupy while the driver is in s.
    function automatic ctrl_state_e ctrl_phase(input drv_state_e s);
        ctrl_state_e p;
        unique case (s)
            S_P1:    p = CTRL_START;
            S_P2:    p = CTRL_STOP;
            S_P3:    p = CTRL_STOP;
            S_P4:    p = CTRL_CLEAR;
            default: p = CTRL_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/fsm_seq_driver_timer.sv
// Loadable TW-bit down counter with zero flag; saturates at zero, never wraps.
module fsm_drv_timer #(
    parameter int TW = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] value_q;
    logic [TW-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - TW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign zero = (value_q == '0);

endmodule

// File: rtl/fsm_seq_driver.sv
// Initiator for the A/K1/K2 four-phase controller protocol with K timeouts.
// Define FSM_DRV_CNT_EN to enable the completed-cycle counter on cyc_cnt.
import fsm_seq_driver_pkg::*;

module fsm_seq_driver #(
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             go,
    input  logic             K1,
    input  logic             K2,
    output logic             A,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
    localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT - 1);

    drv_state_e    state_q, state_d;
    logic          a_q, a_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_zero;

    fsm_drv_timer #(
        .TW (TW)
    ) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        unique case (state_q)
            S_IDLE: begin
                a_d = 1'b0;
                if (go) begin
                    state_d      = S_P1;
                    a_d          = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                end
            end
            S_P1: begin
                if (tmr_zero) begin
                    state_d      = S_P2;
                    a_d          = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                end
            end
            S_P2: begin
                if (tmr_zero) begin
                    state_d      = S_P3;
                    a_d          = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = TO_LD;
                end
            end
            // An out-of-order K beats both success and timeout; a K on the last timer cycle still succeeds.
            S_P3: begin
                if (K1) begin
                    state_d = S_ERR;
                    a_d     = 1'b0;
                end else if (K2) begin
                    state_d      = S_P4;
                    a_d          = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TO_LD;
                end else if (tmr_zero) begin
                    state_d = S_ERR;
                    a_d     = 1'b0;
                end
            end
            S_P4: begin
                a_d = 1'b0;
                if (K2) begin
                    state_d = S_ERR;
                end else if (K1) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                a_d     = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                a_d     = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                a_d     = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign A    = a_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

`ifdef FSM_DRV_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter steps on the same edge done rises, so it already reads the new total during the pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (done_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cyc_cnt = cnt_q;
`else
    assign cyc_cnt = '0;
`endif

endmodule
